ps2_mouse_tracker: RTL and testbench

Receives the raw PS/2 mouse line and keeps an absolute, screen-clamped cursor position and button state. It sits directly upstream of the pixel drawing controller, which consumes `mouseX`/`mouseY` for the cursor square. The block is receive-only. Enabling mouse data reporting (host command 0xF4) is handled by `ps2_host_tx`, outside this block.

---
 rtl/mouse_pkg.sv | 17 +
 rtl/ps2_rx_byte.sv | 80 ++++++++
 rtl/ps2_mouse_tracker.sv | 89 ++++++++
 tb/tb_ps2_mouse_tracker.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
// mouse_pkg: shared receiver states, byte-0 field positions, screen bounds and clamp helper.
package mouse_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;
  localparam int B0_L = 0;
  localparam int B0_R = 1;
  localparam int B0_M = 2;
  localparam int B0_SYNC = 3;
  localparam int B0_XS = 4;
  localparam int B0_YS = 5;
  localparam int B0_XO = 6;
  localparam int B0_YO = 7;
  localparam int X_MAX_DEF = 639;
  localparam int Y_MAX_DEF = 479;
  function automatic logic [10:0] clamp(input logic [12:0] v, input logic [10:0] mx);
    return v[12] ? 11'd0 : (v > {2'b00, mx}) ? mx : v[10:0];
  endfunction
endpackage

// File: rtl/ps2_rx_byte.sv
// ps2_rx_byte: synchronizes the PS/2 line and deframes odd-parity bytes with an idle timeout.
module ps2_rx_byte
  import mouse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  input  logic       pktBusy,
  output logic       byteValid,
  output logic [7:0] byteData,
  output logic       byteErr,
  output logic       timeoutHit
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [1:0] c_q, d_q;
  logic cp_q, par_q;
  rx_state_e st_q;
  logic [2:0] n_q;
  logic [7:0] sh_q;
  logic [TW-1:0] to_q;
  logic fall, b;
  assign fall = cp_q & ~c_q[1];
  assign b = d_q[1];
  assign byteData = sh_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_q <= '0;
      d_q <= '0;
      cp_q <= 1'b0;
      par_q <= 1'b0;
      st_q <= IDLE;
      n_q <= '0;
      sh_q <= '0;
      to_q <= '0;
      byteValid <= 1'b0;
      byteErr <= 1'b0;
      timeoutHit <= 1'b0;
    end else begin
      c_q <= {c_q[0], ps2Clk};
      d_q <= {d_q[0], ps2Data};
      cp_q <= c_q[1];
      byteValid <= 1'b0;
      byteErr <= 1'b0;
      timeoutHit <= 1'b0;
      if (fall) begin
        to_q <= '0;
        case (st_q)
          IDLE: if (!b) begin
            st_q <= DATA;
            n_q <= '0;
          end
          DATA: begin
            sh_q <= {b, sh_q[7:1]};
            n_q <= n_q + 3'd1;
            if (n_q == 3'd7) st_q <= PARITY;
          end
          PARITY: begin
            par_q <= b;
            st_q <= STOP;
          end
          STOP: begin
            st_q <= IDLE;
            byteValid <= b & (^{sh_q, par_q});
            byteErr <= ~(b & (^{sh_q, par_q}));
          end
        endcase
      end else if (st_q != IDLE || pktBusy) begin
        // A falling edge in the expiry cycle takes the branch above, so the edge wins.
        if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
          to_q <= '0;
          st_q <= IDLE;
          timeoutHit <= 1'b1;
        end else to_q <= to_q + 1'b1;
      end else to_q <= '0;
    end
  end
endmodule

// File: rtl/ps2_mouse_tracker.sv
// ps2_mouse_tracker: assembles 3-byte PS/2 mouse packets into a clamped cursor position and buttons.
module ps2_mouse_tracker
  import mouse_pkg::*;
#(
  parameter int X_MAX = X_MAX_DEF,
  parameter int Y_MAX = Y_MAX_DEF,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2Clk,
  input  logic        ps2Data,
  output logic [10:0] mouseX,
  output logic [10:0] mouseY,
  output logic [2:0]  buttons,
  output logic        packetValid,
  output logic        frameError
);
  logic byteValid, byteErr, timeoutHit;
  logic [7:0] byteData;
  logic [1:0] idx_q;
  logic [2:0] btn_q, bp_q;
  logic xs_q, ys_q, xo_q, yo_q;
  logic [7:0] b1_q;
  logic [10:0] x_q, y_q, x_d, y_d;
  logic [12:0] dx, dy;
  logic pv_q, fe_q;
  ps2_rx_byte #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk(clk),
    .reset(reset),
    .ps2Clk(ps2Clk),
    .ps2Data(ps2Data),
    .pktBusy(idx_q != 2'd0),
    .byteValid(byteValid),
    .byteData(byteData),
    .byteErr(byteErr),
    .timeoutHit(timeoutHit)
  );
  always_comb begin
    dx = xo_q ? 13'd0 : {{5{xs_q}}, b1_q};
    dy = yo_q ? 13'd0 : {{5{ys_q}}, byteData};
    x_d = clamp({2'b00, x_q} + dx, 11'(X_MAX));
    y_d = clamp({2'b00, y_q} - dy, 11'(Y_MAX));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
      bp_q <= '0;
      {xs_q, ys_q, xo_q, yo_q} <= '0;
      b1_q <= '0;
      x_q <= 11'(X_INIT);
      y_q <= 11'(Y_INIT);
      btn_q <= '0;
      pv_q <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      pv_q <= 1'b0;
      fe_q <= byteErr;
      if (byteErr || timeoutHit) idx_q <= '0;
      else if (byteValid) begin
        case (idx_q)
          2'd0: if (byteData[B0_SYNC]) begin
            bp_q <= {byteData[B0_M], byteData[B0_R], byteData[B0_L]};
            {xs_q, ys_q, xo_q, yo_q} <= {byteData[B0_XS], byteData[B0_YS], byteData[B0_XO], byteData[B0_YO]};
            idx_q <= 2'd1;
          end
          2'd1: begin
            b1_q <= byteData;
            idx_q <= 2'd2;
          end
          default: begin
            x_q <= x_d;
            y_q <= y_d;
            btn_q <= bp_q;
            pv_q <= 1'b1;
            idx_q <= 2'd0;
          end
        endcase
      end
    end
  end
  assign mouseX = x_q;
  assign mouseY = y_q;
  assign buttons = btn_q;
  assign packetValid = pv_q;
  assign frameError = fe_q;
endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// tb_ps2_mouse_tracker: scoreboard bench driving PS/2 frames against a packet-level reference model.
module tb_ps2_mouse_tracker;
  localparam int T = 1000;
  localparam int H = 12;
  logic clk = 1'b0, reset = 1'b1, ps2Clk = 1'b1, ps2Data = 1'b1;
  logic [10:0] mouseX, mouseY;
  logic [2:0] buttons;
  logic packetValid, frameError;
  typedef struct {int x; int y; int b;} exp_t;
  exp_t pq[$];
  int eq[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, last_stop = 0;
  int mx = 320, my = 240, midx = 0, m0 = 0, m1 = 0;

  ps2_mouse_tracker #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk),
    .reset(reset),
    .ps2Clk(ps2Clk),
    .ps2Data(ps2Data),
    .mouseX(mouseX),
    .mouseY(mouseY),
    .buttons(buttons),
    .packetValid(packetValid),
    .frameError(frameError)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int lim(input int v, input int hi);
    return v < 0 ? 0 : (v > hi ? hi : v);
  endfunction

  task automatic model_byte(input int b, input bit ok);
    int dx, dy;
    if (!ok) begin
      midx = 0;
      eq.push_back(1);
    end else if (midx == 0) begin
      if (b & 8) begin
        m0 = b;
        midx = 1;
      end
    end else if (midx == 1) begin
      m1 = b;
      midx = 2;
    end else begin
      dx = (m0 & 64) ? 0 : ((m0 & 16) ? m1 - 256 : m1);
      dy = (m0 & 128) ? 0 : ((m0 & 32) ? b - 256 : b);
      mx = lim(mx + dx, 639);
      my = lim(my - dy, 479);
      pq.push_back('{mx, my, m0 & 7});
      midx = 0;
    end
  endtask

  task automatic line_bit(input bit v);
    @(negedge clk);
    ps2Data = v;
    repeat (H) @(negedge clk);
    ps2Clk = 1'b0;
    last_stop = cyc;
    repeat (H) @(negedge clk);
    ps2Clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0);
    model_byte(int'(b), !(bad_par || bad_stop));
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(b[i]);
    line_bit(~^b ^ bad_par);
    line_bit(~bad_stop);
    ps2Data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a);
    send_byte(b);
    send_byte(c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    pq.delete();
    eq.delete();
    mx = 320;
    my = 240;
    midx = 0;
    repeat (5) begin
      @(negedge clk);
      chk("rst_pulses", int'(packetValid) + int'(frameError), 0);
    end
    chk("rst_x", int'(mouseX), 320);
    chk("rst_y", int'(mouseY), 240);
    chk("rst_btn", int'(buttons), 0);
    ps2Clk = 1'b1;
    ps2Data = 1'b1;
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic idle_timeout();
    repeat (T + 200) @(negedge clk);
    midx = 0;
  endtask

  always @(negedge clk) begin
    if (!reset && packetValid) begin
      if (pq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_packetValid: got pulse, expected none");
      end else begin
        exp_t e;
        e = pq.pop_front();
        chk("pkt_x", int'(mouseX), e.x);
        chk("pkt_y", int'(mouseY), e.y);
        chk("pkt_btn", int'(buttons), e.b);
        chk("pkt_latency", cyc - last_stop, 4);
      end
    end
    if (!reset && frameError) begin
      if (eq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_frameError: got pulse, expected none");
      end else begin
        void'(eq.pop_front());
        chk("err_latency", cyc - last_stop, 4);
      end
    end
  end

  initial begin
    logic [7:0] b0, b1, b2;
    int k, r;
    do_reset();
    send_pkt(8'h09, 8'h0A, 8'h05);
    chk("basic_x", int'(mouseX), 330);
    chk("basic_y", int'(mouseY), 235);
    chk("basic_btn", int'(buttons), 1);
    do_reset();
    send_pkt(8'h18, 8'h00, 8'h00);
    chk("xclamp1_x", int'(mouseX), 64);
    send_pkt(8'h18, 8'h00, 8'h00);
    chk("xclamp2_x", int'(mouseX), 0);
    chk("xclamp_y", int'(mouseY), 240);
    send_pkt(8'h28, 8'h00, 8'h00);
    chk("yclamp_y", int'(mouseY), 479);
    send_pkt(8'h48, 8'h10, 8'h00);
    chk("ovf_x", int'(mouseX), 0);
    send_byte(8'h08);
    send_byte(8'h00, 1'b1, 1'b0);
    send_byte(8'h00);
    send_pkt(8'h08, 8'h01, 8'h00);
    chk("err_recover_x", int'(mouseX), 1);
    send_byte(8'h08);
    idle_timeout();
    send_pkt(8'h08, 8'h02, 8'h00);
    chk("timeout_x", int'(mouseX), 3);
    send_byte(8'h02);
    send_pkt(8'h08, 8'h01, 8'h00);
    chk("stray_x", int'(mouseX), 4);
    for (int it = 0; it < 40; it++) begin
      b0 = 8'($urandom);
      b0[3] = 1'b1;
      if ($urandom_range(0, 3) != 0) b0[7:6] = 2'b00;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0) send_byte(8'($urandom) & 8'hF7);
      else if (r == 1) begin
        send_byte(b0);
        if ($urandom_range(0, 1) == 1) send_byte(b1);
        idle_timeout();
      end else if (r == 2) begin
        k = $urandom_range(0, 2);
        send_byte(b0, k == 0, 1'b0);
        send_byte(b1, 1'b0, k == 1);
        send_byte(b2, k == 2, 1'b0);
      end else send_pkt(b0, b1, b2);
    end
    idle_timeout();
    chk("mid_x", int'(mouseX), mx);
    chk("mid_y", int'(mouseY), my);
    line_bit(1'b0);
    line_bit(1'b1);
    line_bit(1'b0);
    do_reset();
    send_pkt(8'h0A, 8'h05, 8'h03);
    chk("post_rst_x", int'(mouseX), 325);
    chk("post_rst_y", int'(mouseY), 237);
    chk("post_rst_btn", int'(buttons), 2);
    repeat (20) @(negedge clk);
    chk("pkt_queue_empty", pq.size(), 0);
    chk("err_queue_empty", eq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
